// File: rtl/vproc_mem_model.sv
// Multi-port word memory with round-robin arbitration and a fixed-latency,
// fully pipelined response path. It also provides a program-end flag and a cycle counter.
module vproc_mem_model #(
  parameter int          PORT_CNT    = 2,
  parameter int          MEM_W       = 32,
  parameter int          MEM_SZ      = 262144,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] END_ADDR    = 32'h0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [PORT_CNT-1:0]         req_i,
  input  logic [PORT_CNT*32-1:0]      addr_i,
  input  logic [PORT_CNT-1:0]         we_i,
  input  logic [PORT_CNT*MEM_W/8-1:0] be_i,
  input  logic [PORT_CNT*MEM_W-1:0]   wdata_i,
  output logic [PORT_CNT-1:0]         gnt_o,
  output logic [PORT_CNT-1:0]         rvalid_o,
  output logic [PORT_CNT-1:0]         err_o,
  output logic [PORT_CNT*MEM_W-1:0]   rdata_o,
  output logic                        prog_end_o,
  output logic [31:0]                 cycle_cnt_o
);
  localparam int BW    = MEM_W / 8;
  localparam int AW    = $clog2(MEM_SZ);
  localparam int OW    = $clog2(BW);
  localparam int DEPTH = MEM_SZ / BW;
  localparam int PW    = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

  // Handshake: a request is accepted on the rising edge where req_i[p] and
  // gnt_o[p] are both high. Exactly MEM_LATENCY edges later rvalid_o[p] pulses
  // for one cycle, carrying rdata_o/err_o. The model has no response backpressure.

  logic [MEM_W-1:0] mem [DEPTH];

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] cand;
  logic          g_vld;
  logic [PW-1:0] g_port;

  always_comb begin
    g_vld  = 1'b0;
    g_port = '0;
    cand   = '0;
    for (int k = 0; k < PORT_CNT; k++) begin
      cand = PW'((int'(ptr_q) + k) % PORT_CNT);
      if (!g_vld && req_i[cand]) begin
        g_vld  = 1'b1;
        g_port = cand;
      end
    end
    if (!rst_ni) g_vld = 1'b0;
  end

  always_comb begin
    gnt_o = '0;
    if (g_vld) gnt_o[g_port] = 1'b1;
  end

  logic [31:0]       g_addr;
  logic              g_we;
  logic [BW-1:0]     g_be;
  logic [MEM_W-1:0]  g_wdata;
  logic              g_err;
  logic [AW-OW-1:0]  g_idx;
  logic              unused_addr_lsb;

  assign g_addr          = addr_i[g_port*32 +: 32];
  assign g_we            = we_i[g_port];
  assign g_be            = be_i[g_port*BW +: BW];
  assign g_wdata         = wdata_i[g_port*MEM_W +: MEM_W];
  assign g_err           = |g_addr[31:AW];
  assign g_idx           = g_addr[AW-1:OW];
  assign unused_addr_lsb = ^g_addr[OW-1:0];

  // Response entering the pipe; reads see the contents before this edge's write.
  logic             s_err;
  logic [MEM_W-1:0] s_data;
  assign s_err  = g_err;
  assign s_data = (g_err || g_we) ? '0 : mem[g_idx];

  always_ff @(posedge clk_i) begin
    if (g_vld && g_we && !g_err) begin
      for (int b = 0; b < BW; b++) begin
        if (g_be[b]) mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
      end
    end
  end

  logic             t_vld;
  logic [PW-1:0]    t_port;
  logic             t_err;
  logic [MEM_W-1:0] t_data;

  if (MEM_LATENCY > 1) begin : g_pipe
    localparam int D = MEM_LATENCY - 1;
    logic [D-1:0]     v_q;
    logic [D-1:0]     e_q;
    logic [PW-1:0]    port_q [D];
    logic [MEM_W-1:0] data_q [D];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q <= '0;
        e_q <= '0;
        for (int k = 0; k < D; k++) begin
          port_q[k] <= '0;
          data_q[k] <= '0;
        end
      end else begin
        v_q[0]    <= g_vld;
        e_q[0]    <= s_err;
        port_q[0] <= g_port;
        data_q[0] <= s_data;
        for (int k = 1; k < D; k++) begin
          v_q[k]    <= v_q[k-1];
          e_q[k]    <= e_q[k-1];
          port_q[k] <= port_q[k-1];
          data_q[k] <= data_q[k-1];
        end
      end
    end

    assign t_vld  = v_q[D-1];
    assign t_err  = e_q[D-1];
    assign t_port = port_q[D-1];
    assign t_data = data_q[D-1];
  end else begin : g_nopipe
    assign t_vld  = g_vld;
    assign t_err  = s_err;
    assign t_port = g_port;
    assign t_data = s_data;
  end

  // Per-port output registers keep the last response while rvalid_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      rvalid_o <= '0;
      err_o    <= '0;
      rdata_o  <= '0;
    end else begin
      if (g_vld) ptr_q <= PW'((int'(g_port) + 1) % PORT_CNT);
      rvalid_o <= '0;
      if (t_vld) begin
        rvalid_o[t_port]                  <= 1'b1;
        err_o[t_port]                     <= t_err;
        rdata_o[t_port*MEM_W +: MEM_W]    <= t_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_end_o  <= 1'b0;
      cycle_cnt_o <= '0;
    end else begin
      if (!prog_end_o && cycle_cnt_o != 32'hFFFF_FFFF) cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (g_vld && g_port == '0 && !g_we && g_addr == END_ADDR) prog_end_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vproc_mem_model.sv
// Bench for vproc_mem_model: three instances (latency 1, 3, 4) driven by directed
// steps; responses are checked against an expected queue per instance.
module tb_vproc_mem_model;
  localparam int NI = 3;

  logic        clk;
  logic        rst_n     [NI];
  logic [1:0]  req       [NI];
  logic [63:0] addr      [NI];
  logic [1:0]  we        [NI];
  logic [7:0]  be        [NI];
  logic [63:0] wdata     [NI];
  logic [1:0]  gnt       [NI];
  logic [1:0]  rvalid    [NI];
  logic [1:0]  err       [NI];
  logic [63:0] rdata     [NI];
  logic        prog_end  [NI];
  logic [31:0] cycle_cnt [NI];

  // Entry layout: {due_cycle[15:0], port, err, rdata[31:0]}
  logic [49:0] exp_q [NI][$];
  int          rel   [NI];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [49:0] mon_e;
  logic [1:0]  mon_rv;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    vproc_mem_model #(
      .PORT_CNT(2), .MEM_W(32), .MEM_SZ(262144),
      .MEM_LATENCY((gi == 0) ? 1 : ((gi == 1) ? 3 : 4)),
      .END_ADDR(32'h0000_1000)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n[gi]), .req_i(req[gi]), .addr_i(addr[gi]),
      .we_i(we[gi]), .be_i(be[gi]), .wdata_i(wdata[gi]), .gnt_o(gnt[gi]),
      .rvalid_o(rvalid[gi]), .err_o(err[gi]), .rdata_o(rdata[gi]),
      .prog_end_o(prog_end[gi]), .cycle_cnt_o(cycle_cnt[gi])
    );
  end

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic chk(input int i, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL u%0d %s: observed %0h expected %0h", i, tag, obs, exp);
    end
  endtask

  // Driver: present one access on both lanes, check the grant, queue the response.
  task automatic acc(input int i, input logic [1:0] rq, input int exp_p, input logic w,
                     input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_e);
    logic [1:0] eg;
    req[i] = rq; we[i] = {w, w}; addr[i] = {a, a}; be[i] = {b, b}; wdata[i] = {d, d};
    #1;
    if (exp_p < 0) eg = 2'b00;
    else eg = 2'b01 << exp_p;
    chk(i, "gnt", {62'd0, gnt[i]}, {62'd0, eg});
    if (exp_p >= 0) exp_q[i].push_back({16'(cyc + lat(i)), exp_p[0], exp_e, exp_rd});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int i, input int n);
    req[i] = 2'b00;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard: every cycle, rvalid must match the queue head due this cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      mon_rv = 2'b00;
      mon_e  = '0;
      if (exp_q[i].size() > 0 && int'(exp_q[i][0][49:34]) == cyc) begin
        mon_e  = exp_q[i].pop_front();
        mon_rv = 2'b01 << mon_e[33];
      end
      chk(i, "rvalid", {62'd0, rvalid[i]}, {62'd0, mon_rv});
      if (mon_rv != 2'b00) begin
        chk(i, "rdata", {32'd0, rdata[i][mon_e[33]*32 +: 32]}, {32'd0, mon_e[31:0]});
        chk(i, "err", {63'd0, err[i][mon_e[33]]}, {63'd0, mon_e[32]});
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; req[i] = '0; addr[i] = '0; we[i] = '0; be[i] = '0; wdata[i] = '0;
      rel[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      req[i] = 2'b11;
      #1;
      chk(i, "gnt_in_reset", {62'd0, gnt[i]}, 64'd0);
      chk(i, "cnt_in_reset", {32'd0, cycle_cnt[i]}, 64'd0);
      chk(i, "rdata_in_reset", rdata[i], 64'd0);
      chk(i, "prog_end_in_reset", {63'd0, prog_end[i]}, 64'd0);
      req[i] = 2'b00;
    end
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b1;
      rel[i] = cyc;
    end
    @(posedge clk); #1;

    // Latency 1: both ports requesting from reset alternate 0,1,0,1 (writes preload memory)
    acc(0, 2'b11, 0, 1'b1, 32'h40,   4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    acc(0, 2'b11, 1, 1'b1, 32'h1000, 4'hF, 32'h600D_F00D, 32'h0, 1'b0);
    acc(0, 2'b11, 0, 1'b1, 32'h80,   4'hF, 32'h1234_5678, 32'h0, 1'b0);
    acc(0, 2'b11, 1, 1'b1, 32'h100,  4'hF, 32'h0,         32'h0, 1'b0);
    // Single read, then response held while rvalid is low
    acc(0, 2'b01, 0, 1'b0, 32'h40, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    idle(0, 2);
    chk(0, "hold_rdata", {32'd0, rdata[0][31:0]}, 64'hDEAD_BEEF);
    chk(0, "hold_err", {63'd0, err[0][0]}, 64'd0);
    // Round-robin with mixed request patterns; low address bits ignored
    acc(0, 2'b10, 1, 1'b0, 32'h83, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
    acc(0, 2'b11, 0, 1'b0, 32'h40, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    acc(0, 2'b11, 1, 1'b0, 32'h80, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
    // Out-of-range accesses: error, zero data, no aliasing write
    acc(0, 2'b01, 0, 1'b0, 32'h0004_0000, 4'h0, 32'h0, 32'h0, 1'b1);
    acc(0, 2'b01, 0, 1'b1, 32'h0004_0040, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    acc(0, 2'b01, 0, 1'b0, 32'h40, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    idle(0, 1);
    chk(0, "cycle_cnt", {32'd0, cycle_cnt[0]}, 64'(cyc - rel[0]));
    // Program end at cycle 50
    while (cyc - rel[0] < 50) begin @(posedge clk); #1; end
    chk(0, "cnt_at_50", {32'd0, cycle_cnt[0]}, 64'd50);
    chk(0, "prog_end_before", {63'd0, prog_end[0]}, 64'd0);
    acc(0, 2'b01, 0, 1'b0, 32'h1000, 4'h0, 32'h0, 32'h600D_F00D, 1'b0);
    chk(0, "prog_end_set", {63'd0, prog_end[0]}, 64'd1);
    chk(0, "cnt_frozen_a", {32'd0, cycle_cnt[0]}, 64'd51);
    idle(0, 5);
    chk(0, "cnt_frozen_b", {32'd0, cycle_cnt[0]}, 64'd51);
    chk(0, "prog_end_sticky", {63'd0, prog_end[0]}, 64'd1);

    // Latency 3: byte-enable merge on port 1, back-to-back pipelined
    acc(1, 2'b10, 1, 1'b1, 32'h100, 4'hF,    32'hAAAA_AAAA, 32'h0, 1'b0);
    acc(1, 2'b10, 1, 1'b1, 32'h100, 4'b0101, 32'h1122_3344, 32'h0, 1'b0);
    acc(1, 2'b10, 1, 1'b0, 32'h100, 4'h0,    32'h0,         32'hAA22_AA44, 1'b0);
    idle(1, 4);
    chk(1, "cycle_cnt", {32'd0, cycle_cnt[1]}, 64'(cyc - rel[1]));

    // Latency 4: reset while a read is in flight
    acc(2, 2'b01, 0, 1'b1, 32'h200, 4'hF, 32'hCAFE_BABE, 32'h0, 1'b0);
    idle(2, 5);
    acc(2, 2'b01, 0, 1'b0, 32'h200, 4'h0, 32'h0, 32'hCAFE_BABE, 1'b0);
    req[2] = 2'b00;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    exp_q[2].delete();
    #1;
    chk(2, "rvalid_reset", {62'd0, rvalid[2]}, 64'd0);
    chk(2, "rdata_reset", rdata[2], 64'd0);
    chk(2, "err_reset", {62'd0, err[2]}, 64'd0);
    chk(2, "cnt_reset", {32'd0, cycle_cnt[2]}, 64'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    rel[2] = cyc;
    idle(2, 6);
    acc(2, 2'b01, 0, 1'b0, 32'h200, 4'h0, 32'h0, 32'hCAFE_BABE, 1'b0);
    idle(2, 5);
    chk(2, "cycle_cnt", {32'd0, cycle_cnt[2]}, 64'(cyc - rel[2]));

    for (int i = 0; i < NI; i++) chk(i, "drain", 64'(exp_q[i].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
